ema_in_fifo: RTL and testbench

Input buffer and issue sequencer directly upstream of the EMA filter core. It accepts a free-running sample stream that cannot be stalled and stores samples in a circular FIFO. It issues one sample at a time to the EMA core using the core's single-cycle `valid` pulse and `bussy` handshake. Samples arriving while the core is computing are queued instead of lost.

---
 rtl/ema_pkg.sv | 25 ++
 rtl/ema_fifo_mem.sv | 62 ++++++
 rtl/ema_in_fifo.sv | 127 ++++++++++++
 tb/tb_ema_in_fifo.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ema_pkg.sv
// Purpose: shared constants and issue-FSM encoding for the EMA input path and core.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ema_pkg;

  // Sample width shared by the input FIFO and the EMA core (core Win).
  localparam int EMA_W = 16;

  // Default number of cycles to wait for the core to raise busy after an issue pulse.
  localparam int EMA_ARM_TO = 4;

  // Issue sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ARM   = 2'd2,
    ST_BUSY  = 2'd3
  } issue_st_t;

  // Counter width able to hold 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ema_fifo_mem.sv
// Purpose: circular sample RAM with AW+1-bit pointers, registered read port and level/full/empty.
// Latency: write visible to the read side one edge after the push; read data registered on the pop edge.
// Backpressure: none upstream; a write while full is accepted only if a pop happens in the same cycle, else flagged as a drop.
module ema_fifo_mem #(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_vld,
  input  logic [W-1:0]  wr_dat,
  input  logic          rd_vld,
  output logic [W-1:0]  rd_dat,
  output logic          wr_drop,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         rd_acc;
  logic         wr_acc;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_acc  = rd_vld && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still take the write.
  assign wr_acc  = wr_vld && (!full || rd_acc);
  assign wr_drop = wr_vld && !wr_acc;
  // Pointer difference modulo 2*DEPTH is the occupancy.
  assign level   = wr_ptr - rd_ptr;

  // Advance pointers on accepted writes and pops.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array; contents need no reset since pointers gate every read.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end

  // Registered read port: loads the head on a pop and holds it otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_dat <= '0;
    end else if (rd_acc) begin
      rd_dat <= mem[rd_ptr[AW-1:0]];
    end
  end

endmodule

// File: rtl/ema_in_fifo.sv
// Purpose: buffers a non-stallable sample stream and issues one sample per EMA core computation.
// Latency: sample strobed in cycle t with empty FIFO and idle core gives valid_o in cycle t+2.
// Backpressure: upstream never stalls; s_ready_o is informational, samples arriving while full are dropped.
// Optional: define EMA_IN_FIFO_DROPCNT_EN to add the saturating drop_cnt_o counter.
module ema_in_fifo
  import ema_pkg::*;
#(
  parameter int W      = EMA_W,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH),
  parameter int ARM_TO = EMA_ARM_TO
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  s_data_i,
  input  logic          s_valid_i,
  output logic          s_ready_o,
  output logic [W-1:0]  x_o,
  output logic          valid_o,
  input  logic          busy_i,
  output logic [AW:0]   level_o,
  output logic          ovf_o,
  output logic          err_o
`ifdef EMA_IN_FIFO_DROPCNT_EN
  ,
  output logic [15:0]   drop_cnt_o
`endif
);

  localparam int CW = cnt_w(ARM_TO);
  localparam logic [CW-1:0] ARM_LAST = CW'(ARM_TO - 1);

  issue_st_t      state;
  issue_st_t      state_nxt;
  logic           pop;
  logic           arm_to_hit;
  logic           wr_drop;
  logic           full;
  logic           empty;
  logic [CW-1:0]  arm_cnt;

  ema_fifo_mem #(
    .W     (W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_vld  (s_valid_i),
    .wr_dat  (s_data_i),
    .rd_vld  (pop),
    .rd_dat  (x_o),
    .wr_drop (wr_drop),
    .full    (full),
    .empty   (empty),
    .level   (level_o)
  );

  assign s_ready_o = !full;

  // Issue FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Issue FSM next state and outputs; pops only from IDLE so one issue maps to one computation.
  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    valid_o    = 1'b0;
    arm_to_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty && !busy_i) begin
          pop       = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        valid_o   = 1'b1;
        state_nxt = ST_ARM;
      end
      ST_ARM: begin
        if (busy_i) begin
          state_nxt = ST_BUSY;
        end else if (arm_cnt == ARM_LAST) begin
          arm_to_hit = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (!busy_i) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Counts cycles spent in ARM; cleared whenever the FSM is elsewhere.
  always_ff @(posedge clk) begin
    if (rst || state != ST_ARM) arm_cnt <= '0;
    else                        arm_cnt <= arm_cnt + 1'b1;
  end

  // Sticky overflow and missing-busy error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      if (wr_drop)    ovf_o <= 1'b1;
      if (arm_to_hit) err_o <= 1'b1;
    end
  end

`ifdef EMA_IN_FIFO_DROPCNT_EN
  // Saturating count of dropped samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_o <= '0;
    end else if (wr_drop && drop_cnt_o != 16'hFFFF) begin
      drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ema_in_fifo.sv
module tb_ema_in_fifo;

  localparam int W     = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  s_data_i;
  logic          s_valid_i;
  logic          s_ready_o;
  logic [W-1:0]  x_o;
  logic          valid_o;
  logic          busy_i;
  logic [AW:0]   level_o;
  logic          ovf_o;
  logic          err_o;
`ifdef EMA_IN_FIFO_DROPCNT_EN
  logic [15:0]   drop_cnt_o;
`endif

  always #5 clk = ~clk;

  ema_in_fifo dut (
    .clk       (clk),
    .rst       (rst),
    .s_data_i  (s_data_i),
    .s_valid_i (s_valid_i),
    .s_ready_o (s_ready_o),
    .x_o       (x_o),
    .valid_o   (valid_o),
    .busy_i    (busy_i),
    .level_o   (level_o),
    .ovf_o     (ovf_o),
    .err_o     (err_o)
`ifdef EMA_IN_FIFO_DROPCNT_EN
    ,
    .drop_cnt_o(drop_cnt_o)
`endif
  );

  int            n_checks = 0;
  int            n_err    = 0;
  int            n_pulse  = 0;
  logic [W-1:0]  exp_q[$];

  // Core model: 0 = EMA core (busy two cycles after the pulse, for comp cycles),
  // 1 = busy forced high, 2 = dead core (busy never rises).
  int            core_mode = 0;
  int            comp      = 3;
  logic          core_vld_d;
  int            core_cnt;

  always @(posedge clk) begin
    if (rst) begin
      core_vld_d <= 1'b0;
      busy_i     <= 1'b0;
      core_cnt   <= 0;
    end else if (core_mode == 1) begin
      core_vld_d <= 1'b0;
      busy_i     <= 1'b1;
      core_cnt   <= 0;
    end else if (core_mode == 2) begin
      core_vld_d <= 1'b0;
      busy_i     <= 1'b0;
      core_cnt   <= 0;
    end else begin
      core_vld_d <= valid_o;
      if (core_vld_d) begin
        busy_i   <= 1'b1;
        core_cnt <= comp - 1;
      end else if (busy_i) begin
        if (core_cnt == 0) busy_i <= 1'b0;
        else               core_cnt <= core_cnt - 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [W-1:0] v);
    s_valid_i = 1'b1;
    s_data_i  = v;
    exp_q.push_back(v);
    step();
    s_valid_i = 1'b0;
  endtask

  // Wait until the block has been quiet for 8 cycles, bounded by budget.
  task automatic wait_idle(input int budget);
    int quiet = 0;
    int k = 0;
    while (quiet < 8 && k < budget) begin
      @(negedge clk);
      k++;
      if (!busy_i && level_o == '0 && !valid_o) quiet++;
      else quiet = 0;
    end
    if (quiet < 8) begin
      n_checks++;
      n_err++;
      $display("FAIL wait_idle: still active after %0d cycles, expected idle", budget);
    end
    step();
  endtask

  // Monitor: every issue pulse pops the scoreboard; x_o must then hold for the core's sampling point.
  initial begin : monitor
    int hold = 0;
    logic [W-1:0] hv;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 0;
      end else begin
        if (hold > 0) begin
          chk("x_hold", 32'(x_o), 32'(hv));
          hold--;
        end
        if (valid_o) begin
          n_pulse++;
          chk("no_issue_while_busy", 32'(busy_i), 0);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_pulse: x_o=0x%0h, expected no pulse", x_o);
          end else begin
            chk("issue_data", 32'(x_o), 32'(exp_q.pop_front()));
          end
          hold = 2;
          hv   = x_o;
        end
      end
    end
  end

  initial begin : stim
    int base;
    int k;
    rst       = 1'b1;
    s_valid_i = 1'b0;
    s_data_i  = '0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_x", 32'(x_o), 0);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_ready", 32'(s_ready_o), 1);
    chk("rst_level", 32'(level_o), 0);
    chk("rst_ovf", 32'(ovf_o), 0);
    chk("rst_err", 32'(err_o), 0);
`ifdef EMA_IN_FIFO_DROPCNT_EN
    chk("rst_drop_cnt", 32'(drop_cnt_o), 0);
`endif
    step();
    rst = 1'b0;
    step();

    // Single sample latency.
    comp = 3;
    s_valid_i = 1'b1;
    s_data_i  = 16'h1234;
    exp_q.push_back(16'h1234);
    @(negedge clk);
    chk("t0_valid", 32'(valid_o), 0);
    chk("t0_level", 32'(level_o), 0);
    step();
    s_valid_i = 1'b0;
    @(negedge clk);
    chk("t1_level", 32'(level_o), 1);
    chk("t1_valid", 32'(valid_o), 0);
    step();
    @(negedge clk);
    chk("t2_valid", 32'(valid_o), 1);
    chk("t2_x", 32'(x_o), 32'h1234);
    chk("t2_level", 32'(level_o), 0);
    step();
    @(negedge clk);
    chk("t3_valid", 32'(valid_o), 0);
    wait_idle(100);

    // Burst of 5 with a slow core.
    comp = 12;
    base = n_pulse;
    for (int i = 1; i <= 5; i++) strobe(W'(i));
    wait_idle(300);
    chk("burst_pulses", n_pulse - base, 5);
    chk("burst_ovf", 32'(ovf_o), 0);
    chk("burst_queue", exp_q.size(), 0);

    // Overflow with the core held busy.
    core_mode = 1;
    step();
    step();
    for (int i = 0; i < DEPTH + 2; i++) begin
      s_valid_i = 1'b1;
      s_data_i  = W'(16'h0100 + i);
      if (i < DEPTH) exp_q.push_back(s_data_i);
      if (i == DEPTH) begin
        @(negedge clk);
        chk("ovf_pre_level", 32'(level_o), DEPTH);
        chk("ovf_pre_flag", 32'(ovf_o), 0);
      end
      step();
    end
    s_valid_i = 1'b0;
    @(negedge clk);
    chk("ovf_level", 32'(level_o), DEPTH);
    chk("ovf_ready", 32'(s_ready_o), 0);
    chk("ovf_flag", 32'(ovf_o), 1);
`ifdef EMA_IN_FIFO_DROPCNT_EN
    chk("ovf_drop_cnt", 32'(drop_cnt_o), 2);
`endif
    step();

    // Full with a simultaneous pop.
    rst = 1'b1;
    exp_q.delete();
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("fwp_rst_level", 32'(level_o), 0);
    chk("fwp_rst_ovf", 32'(ovf_o), 0);
    step();
    for (int i = 0; i < DEPTH; i++) strobe(W'(16'h0200 + i));
    @(negedge clk);
    chk("fwp_fill_level", 32'(level_o), DEPTH);
    chk("fwp_fill_ready", 32'(s_ready_o), 0);
    chk("fwp_fill_ovf", 32'(ovf_o), 0);
    step();
    core_mode = 0;
    step();
    s_valid_i = 1'b1;
    s_data_i  = 16'h02AA;
    exp_q.push_back(16'h02AA);
    @(negedge clk);
    chk("fwp_busy_fell", 32'(busy_i), 0);
    chk("fwp_level_before", 32'(level_o), DEPTH);
    step();
    s_valid_i = 1'b0;
    @(negedge clk);
    chk("fwp_level_after", 32'(level_o), DEPTH);
    chk("fwp_ovf", 32'(ovf_o), 0);
    chk("fwp_valid", 32'(valid_o), 1);
`ifdef EMA_IN_FIFO_DROPCNT_EN
    chk("fwp_drop_cnt", 32'(drop_cnt_o), 0);
`endif
    comp = 2;
    wait_idle(400);
    chk("fwp_drained", exp_q.size(), 0);

    // Timeout: dead core, two samples queued.
    core_mode = 2;
    step();
    strobe(16'h00A1);
    strobe(16'h00B2);
    @(negedge clk);
    chk("to_first_valid", 32'(valid_o), 1);
    repeat (4) @(negedge clk);
    chk("to_err_before", 32'(err_o), 0);
    @(negedge clk);
    chk("to_err", 32'(err_o), 1);
    chk("to_gap_valid", 32'(valid_o), 0);
    @(negedge clk);
    chk("to_next_valid", 32'(valid_o), 1);
    chk("to_next_x", 32'(x_o), 32'h00B2);
    wait_idle(100);

    // Reset while the core is busy with three samples queued.
    core_mode = 0;
    comp = 12;
    step();
    for (int i = 0; i < 4; i++) strobe(W'(16'h0300 + i));
    k = 0;
    @(negedge clk);
    while (!busy_i && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("mid_busy_seen", 32'(busy_i), 1);
    chk("mid_level", 32'(level_o), 3);
    step();
    rst = 1'b1;
    exp_q.delete();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_level", 32'(level_o), 0);
    chk("mid_rst_x", 32'(x_o), 0);
    chk("mid_rst_valid", 32'(valid_o), 0);
    chk("mid_rst_err", 32'(err_o), 0);
    base = n_pulse;
    repeat (30) @(negedge clk);
    chk("mid_rst_no_pulse", n_pulse - base, 0);
    step();

    // Random traffic with a variable-latency core, throttled so nothing is dropped.
    for (int seg = 0; seg < 4; seg++) begin
      comp = int'($urandom_range(1, 8));
      for (int c = 0; c < 100; c++) begin
        if ($urandom_range(0, 2) == 0 && exp_q.size() < DEPTH) begin
          s_valid_i = 1'b1;
          s_data_i  = W'($urandom);
          exp_q.push_back(s_data_i);
        end else begin
          s_valid_i = 1'b0;
        end
        step();
      end
    end
    s_valid_i = 1'b0;
    wait_idle(600);
    chk("rnd_queue", exp_q.size(), 0);
    chk("rnd_ovf", 32'(ovf_o), 0);
    chk("rnd_err", 32'(err_o), 0);
    chk("rnd_level", 32'(level_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
